slab_compare_sched: RTL and testbench



---
 rtl/slab_compare_sched_pkg.sv | 38 +++
 rtl/slab_compare_sched_greater_than.sv | 46 ++++
 rtl/slab_compare_sched.sv | 189 ++++++++++++++++++
 tb/tb_slab_compare_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slab_compare_sched_pkg.sv
// Shared types and constants for the ray/AABB slab-reduction scheduler.
// Latency: n/a (package only).
// Backpressure: n/a. Macro SLAB_TMAX_POS_EN adds the "box in front of origin" step.
package slab_compare_sched_pkg;

    // FloPoCo word: [17:16] exception, [15] sign, [14:11] exponent, [10:0] fraction
    localparam int FP_W   = 18;
    localparam int EXC_HI = FP_W - 1;
    localparam int EXC_LO = FP_W - 2;
    localparam int SIGN   = FP_W - 3;

    localparam logic [1:0]      EXC_NORM = 2'b01;
    localparam logic [FP_W-1:0] FP_ZERO  = '0;   // exc=00 encodes zero

`ifdef SLAB_TMAX_POS_EN
    localparam int N_CMP = 6;
`else
    localparam int N_CMP = 5;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMP,
        S_WAIT,
        S_UPD,
        S_DONE
    } state_t;

    // Comparison steps, issued in this order
    localparam logic [2:0] STEP_NEAR_XY = 3'd0;  // (nx, ny)     tmin = g ? A : B
    localparam logic [2:0] STEP_NEAR_Z  = 3'd1;  // (tmin, nz)   tmin = g ? A : B
    localparam logic [2:0] STEP_FAR_XY  = 3'd2;  // (fx, fy)     tmax = g ? B : A
    localparam logic [2:0] STEP_FAR_Z   = 3'd3;  // (tmax, fz)   tmax = g ? B : A
    localparam logic [2:0] STEP_HIT     = 3'd4;  // (tmax, tmin) hit = g
    localparam logic [2:0] STEP_POS     = 3'd5;  // (tmax, 0)    hit = hit & g
    localparam logic [2:0] LAST_STEP    = 3'(N_CMP - 1);

endpackage

// File: rtl/slab_compare_sched_greater_than.sv
// Strict A > B test on FloPoCo words, pipelined to LAT cycles (stands in for FPSub + sign/exc test).
// Latency: LAT cycles from operand presentation to gt_o.
// Backpressure: none; free-running pipeline, caller holds operands stable.
// Ports: clk/rst, a_i/b_i operands, gt_o = 1 only when both are finite and A is strictly greater.
module slab_compare_sched_greater_than
    import slab_compare_sched_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] a_i,
    input  logic [FP_W-1:0] b_i,
    output logic            gt_o
);

    // Map to a signed integer whose order matches the real value; zero (any sign) maps to 0,
    // and the implicit leading one keeps the smallest normal above zero.
    function automatic logic signed [FP_W-2:0] to_int(input logic [FP_W-1:0] v);
        logic [FP_W-3:0] mag;
        mag    = (v[EXC_HI:EXC_LO] == EXC_NORM) ? {1'b1, v[SIGN-1:0]} : '0;
        to_int = v[SIGN] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    endfunction

    logic           fin_ab;
    logic           gt_raw;
    logic [LAT-1:0] pipe_q;

    // Inf/NaN on either side makes the difference non-normal, so the result is "not greater"
    assign fin_ab = !a_i[EXC_HI] && !b_i[EXC_HI];
    assign gt_raw = fin_ab && (to_int(a_i) > to_int(b_i));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= gt_raw;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign gt_o = pipe_q[LAT-1];

endmodule

// File: rtl/slab_compare_sched.sv
// Ray/AABB slab reduction (tmin=max near, tmax=min far, hit=tmax>tmin) on one shared comparator.
// Latency: out_valid rises 1+N_CMP*(CMP_LAT+2) cycles after accept.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Macro: SLAB_TMAX_POS_EN.
// Ports: in_valid/in_ready + near_*/far_*/in_id input bundle; out_valid/out_ready + out_hit,
//        out_tmin, out_tmax, out_id result bundle.
module slab_compare_sched
    import slab_compare_sched_pkg::*;
#(
    parameter int CMP_LAT = 3,
    parameter int ID_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] near_x,
    input  logic [FP_W-1:0] near_y,
    input  logic [FP_W-1:0] near_z,
    input  logic [FP_W-1:0] far_x,
    input  logic [FP_W-1:0] far_y,
    input  logic [FP_W-1:0] far_z,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_hit,
    output logic [FP_W-1:0] out_tmin,
    output logic [FP_W-1:0] out_tmax,
    output logic [ID_W-1:0] out_id
);

    localparam int CNT_W = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMP_LAT - 1);

    state_t          state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            g_q, g_d;
    logic [FP_W-1:0] nx_q, ny_q, nz_q, fx_q, fy_q, fz_q;
    logic [FP_W-1:0] nx_d, ny_d, nz_d, fx_d, fy_d, fz_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [FP_W-1:0] tmin_q, tmin_d, tmax_q, tmax_d;
    logic            hit_q, hit_d;
    logic            out_valid_q, out_valid_d, out_hit_q, out_hit_d;
    logic [FP_W-1:0] out_tmin_q, out_tmin_d, out_tmax_q, out_tmax_d;
    logic [ID_W-1:0] out_id_q, out_id_d;

    logic [FP_W-1:0] op_a, op_b;
    logic            gt;

    // Operands depend only on the step index, so they stay stable from CMP through UPD
    always_comb begin
        op_a = FP_ZERO;
        op_b = FP_ZERO;
        case (step_q)
            STEP_NEAR_XY: begin op_a = nx_q;   op_b = ny_q;   end
            STEP_NEAR_Z:  begin op_a = tmin_q; op_b = nz_q;   end
            STEP_FAR_XY:  begin op_a = fx_q;   op_b = fy_q;   end
            STEP_FAR_Z:   begin op_a = tmax_q; op_b = fz_q;   end
            STEP_HIT:     begin op_a = tmax_q; op_b = tmin_q; end
            STEP_POS:     begin op_a = tmax_q; op_b = FP_ZERO; end
            default:      ;
        endcase
    end

    slab_compare_sched_greater_than #(.LAT(CMP_LAT)) u_gt (
        .clk  (clk),
        .rst  (rst),
        .a_i  (op_a),
        .b_i  (op_b),
        .gt_o (gt)
    );

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        g_d         = g_q;
        nx_d = nx_q; ny_d = ny_q; nz_d = nz_q;
        fx_d = fx_q; fy_d = fy_q; fz_d = fz_q;
        id_d        = id_q;
        tmin_d      = tmin_q;
        tmax_d      = tmax_q;
        hit_d       = hit_q;
        out_valid_d = out_valid_q;
        out_hit_d   = out_hit_q;
        out_tmin_d  = out_tmin_q;
        out_tmax_d  = out_tmax_q;
        out_id_d    = out_id_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    nx_d = near_x; ny_d = near_y; nz_d = near_z;
                    fx_d = far_x;  fy_d = far_y;  fz_d = far_z;
                    id_d    = in_id;
                    step_d  = STEP_NEAR_XY;
                    hit_d   = 1'b0;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    g_d     = gt;
                    state_d = S_UPD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_UPD: begin
                // g=0 on ties: max keeps B, min keeps A; both are the same value
                case (step_q)
                    STEP_NEAR_XY, STEP_NEAR_Z: tmin_d = g_q ? op_a : op_b;
                    STEP_FAR_XY, STEP_FAR_Z:   tmax_d = g_q ? op_b : op_a;
                    STEP_HIT:                  hit_d  = g_q;
                    STEP_POS:                  hit_d  = hit_q & g_q;
                    default:                   ;
                endcase
                if (step_q == LAST_STEP) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = S_CMP;
                end
            end
            S_DONE: begin
                // First DONE cycle publishes the result; afterwards wait for the handshake
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_hit_d   = hit_q;
                    out_tmin_d  = tmin_q;
                    out_tmax_d  = tmax_q;
                    out_id_d    = id_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            g_q         <= 1'b0;
            nx_q <= '0; ny_q <= '0; nz_q <= '0;
            fx_q <= '0; fy_q <= '0; fz_q <= '0;
            id_q        <= '0;
            tmin_q      <= '0;
            tmax_q      <= '0;
            hit_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_hit_q   <= 1'b0;
            out_tmin_q  <= '0;
            out_tmax_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            g_q         <= g_d;
            nx_q <= nx_d; ny_q <= ny_d; nz_q <= nz_d;
            fx_q <= fx_d; fy_q <= fy_d; fz_q <= fz_d;
            id_q        <= id_d;
            tmin_q      <= tmin_d;
            tmax_q      <= tmax_d;
            hit_q       <= hit_d;
            out_valid_q <= out_valid_d;
            out_hit_q   <= out_hit_d;
            out_tmin_q  <= out_tmin_d;
            out_tmax_q  <= out_tmax_d;
            out_id_q    <= out_id_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_hit   = out_hit_q;
    assign out_tmin  = out_tmin_q;
    assign out_tmax  = out_tmax_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_slab_compare_sched.sv
// Scoreboard bench for slab_compare_sched: directed vectors, backpressure, mid-op reset, random.
// Latency: checks out_valid rise against 1+N*(CMP_LAT+2) after each accept.
// Backpressure: out_ready forced or randomised; in_valid held by the driver while DUT is busy.
module tb_slab_compare_sched;

`ifdef SLAB_TMAX_POS_EN
    localparam int NSTEP  = 6;
    localparam bit POS_EN = 1'b1;
`else
    localparam int NSTEP  = 5;
    localparam bit POS_EN = 1'b0;
`endif
    localparam int CMP_LAT = 3;
    localparam int LAT     = 1 + NSTEP * (CMP_LAT + 2);

    typedef struct {
        logic        hit;
        logic [17:0] tmin;
        logic [17:0] tmax;
        logic [7:0]  id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] near_x = '0, near_y = '0, near_z = '0;
    logic [17:0] far_x = '0, far_y = '0, far_z = '0;
    logic [7:0]  in_id = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_hit;
    logic [17:0] out_tmin, out_tmax;
    logic [7:0]  out_id;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   rand_bp = 1'b0;
    bit   ready_force = 1'b1;
    exp_t exp_q[$];
    int   lat_q[$];

    slab_compare_sched #(.CMP_LAT(CMP_LAT), .ID_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .near_x(near_x), .near_y(near_y), .near_z(near_z),
        .far_x(far_x), .far_y(far_y), .far_z(far_z),
        .in_id(in_id),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hit(out_hit), .out_tmin(out_tmin), .out_tmax(out_tmax), .out_id(out_id)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_bp ? ($urandom_range(0, 2) != 0) : ready_force;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---- reference model: real-valued arithmetic on decoded FloPoCo words ----
    function automatic logic [17:0] fp(input bit s, input int e, input int f);
        logic [3:0]  ex;
        logic [10:0] fr;
        ex = 4'(e + 7);
        fr = 11'(f);
        return {2'b01, s, ex, fr};
    endfunction

    function automatic bit finite(input logic [17:0] v);
        return v[17] == 1'b0;
    endfunction

    function automatic real fp2r(input logic [17:0] v);
        real r;
        int  e;
        if (v[17:16] == 2'b00) return 0.0;
        r = 1.0 + real'(v[10:0]) / 2048.0;
        e = int'(v[14:11]) - 7;
        for (int i = 0; i < e; i++) r = r * 2.0;
        for (int i = 0; i < -e; i++) r = r / 2.0;
        return v[15] ? -r : r;
    endfunction

    function automatic bit gtr(input logic [17:0] a, input logic [17:0] b);
        return finite(a) && finite(b) && (fp2r(a) > fp2r(b));
    endfunction

    function automatic exp_t model(input logic [17:0] nx, ny, nz, fx, fy, fz, input logic [7:0] id);
        exp_t e;
        e.tmin = gtr(nx, ny) ? nx : ny;
        e.tmin = gtr(e.tmin, nz) ? e.tmin : nz;
        e.tmax = gtr(fx, fy) ? fy : fx;
        e.tmax = gtr(e.tmax, fz) ? fz : e.tmax;
        e.hit  = gtr(e.tmax, e.tmin);
        if (POS_EN) e.hit = e.hit & gtr(e.tmax, 18'h0);
        e.id = id;
        return e;
    endfunction

    function automatic logic [17:0] rnd_fp();
        int r;
        int fsel;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 18'h0;
        if (r == 1) return {2'b10, 16'h0};
        fsel = int'($urandom_range(0, 3));
        return fp(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)) - 1, fsel * 512);
    endfunction

    // Holds in_valid with the bundle until the DUT accepts it
    task automatic send(input logic [17:0] nx, ny, nz, fx, fy, fz, input logic [7:0] id,
                        input exp_t e);
        int guard;
        @(negedge clk);
        near_x = nx; near_y = ny; near_z = nz;
        far_x = fx;  far_y = fy;  far_z = fz;
        in_id = id;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        lat_q.push_back(cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // ---- monitor ----
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (lat_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
                else check("latency", 64'(cyc - lat_q.pop_front()), 64'(LAT));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result{hit,tmin,tmax,id}", 64'({out_hit, out_tmin, out_tmax, out_id}),
                          64'({e.hit, e.tmin, e.tmax, e.id}));
                end
            end
            prev_v = out_valid;
        end
    end

    exp_t        ex;
    logic [44:0] held;
    int          guard;

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_hit", 64'(out_hit), 64'd0);
        check("rst_outputs", 64'({out_tmin, out_tmax, out_id}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 1: basic hit
        ex = '{hit: 1'b1, tmin: fp(0, 1, 0), tmax: fp(0, 1, 1024), id: 8'h11};
        send(fp(0, 0, 0), fp(0, 1, 0), fp(0, -1, 0), fp(0, 2, 0), fp(0, 1, 1024), fp(0, 2, 512),
             8'h11, ex);
        // 2: tmax == tmin is a miss
        ex = '{hit: 1'b0, tmin: fp(0, 1, 1024), tmax: fp(0, 1, 1024), id: 8'h22};
        send(fp(0, 0, 0), fp(0, 1, 1024), fp(0, -1, 0), fp(0, 2, 0), fp(0, 1, 1024), fp(0, 2, 512),
             8'h22, ex);
        // 3: all-tie near values, reversed slab
        ex = '{hit: 1'b0, tmin: fp(0, 1, 0), tmax: fp(0, 0, 0), id: 8'h33};
        send(fp(0, 1, 0), fp(0, 1, 0), fp(0, 1, 0), fp(0, 0, 0), fp(0, 2, 1024), fp(0, 2, 1024),
             8'h33, ex);
        // 6: box behind origin
        ex = '{hit: !POS_EN, tmin: fp(1, 1, 1024), tmax: fp(1, 1, 0), id: 8'h66};
        send(fp(1, 2, 0), fp(1, 1, 1024), fp(1, 2, 512), fp(1, 0, 0), fp(1, 1, 0), fp(1, -1, 0),
             8'h66, ex);

        // 4: hold result under backpressure
        guard = 0;
        while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
        ready_force = 1'b0;
        ex = '{hit: 1'b0, tmin: fp(0, 1, 0), tmax: fp(0, 0, 0), id: 8'h44};
        send(fp(0, 1, 0), fp(0, 1, 0), fp(0, 1, 0), fp(0, 0, 0), fp(0, 2, 1024), fp(0, 2, 1024),
             8'h44, ex);
        guard = 0;
        while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
        check("bp_valid_seen", 64'(out_valid), 64'd1);
        held = {out_hit, out_tmin, out_tmax, out_id};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold{valid,in_ready,data}", 64'({out_valid, in_ready, out_hit, out_tmin, out_tmax, out_id}),
                  64'({1'b1, 1'b0, held}));
        end
        ready_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_idle{in_ready,out_valid}", 64'({in_ready, out_valid}), 64'b10);

        // 5: reset during WAIT of step 2
        ex = '{hit: 1'b1, tmin: fp(0, 1, 0), tmax: fp(0, 1, 1024), id: 8'h55};
        send(fp(0, 0, 0), fp(0, 1, 0), fp(0, -1, 0), fp(0, 2, 0), fp(0, 1, 1024), fp(0, 2, 512),
             8'h55, ex);
        repeat (11) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_outputs", 64'({out_valid, out_hit, out_tmin, out_tmax, out_id}), 64'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        if (lat_q.size() > 0) void'(lat_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        ex = '{hit: 1'b1, tmin: fp(0, 1, 0), tmax: fp(0, 1, 1024), id: 8'h56};
        send(fp(0, 0, 0), fp(0, 1, 0), fp(0, -1, 0), fp(0, 2, 0), fp(0, 1, 1024), fp(0, 2, 512),
             8'h56, ex);

        // random traffic with random backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 30; n++) begin
            logic [17:0] v[6];
            logic [7:0]  id;
            for (int k = 0; k < 6; k++) v[k] = rnd_fp();
            id = 8'($urandom_range(0, 255));
            send(v[0], v[1], v[2], v[3], v[4], v[5], id, model(v[0], v[1], v[2], v[3], v[4], v[5], id));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin @(negedge clk); guard++; end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        rand_bp = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
